md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Sequencing controller for the shared multiply/divide resource and its HI/LO registers.
- Accepts one md operation per start pulse, with operands taken from the decode-stage register reads (rs, rt).
- Holds the resource busy for a fixed latency, then commits HI/LO.
- Raises a stall request to the decode stage whenever a younger md instruction would collide with a running operation.

Parameters:
- MULT_CYCLES, 5: busy duration for mult/multu.
- DIV_CYCLES, 10: busy duration for div/divu.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch md_op this cycle; only honoured in IDLE
- md_op  in  3  operation code from md_pkg: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- op_a  in  32  rs value
- op_b  in  32  rt value
- d_is_md  in  1  decode stage holds an md-class instruction (including mfhi/mflo)
- flush  in  1  abort request; functional only with MD_FLUSH_EN
- busy  out  1  operation in progress
- hi  out  32  HI register
- lo  out  32  LO register
- stall_req  out  1  stall decode

Behaviour:
- Reset (async, reset=0):
  - State=IDLE, counter=0.
  - busy=0, stall_req=0, hi=0, lo=0, pending results=0.
- States: IDLE, RUN.
- IDLE with start=1 and op MULT/MULTU/DIV/DIVU:
  - At edge E0, latch op_a and op_b.
  - Compute the pending {hi,lo}.
  - Load counter=N-1, where N=MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN:
  - Counter decrements each edge while nonzero.
  - busy=1 for exactly N cycles after E0.
  - On the edge where RUN has counter==0 (edge E_N): commit pending to hi/lo, return to IDLE, busy=0.
  - New hi/lo are visible in the same cycle busy falls.
- MTHI/MTLO with start=1 in IDLE:
  - Write op_a to hi or lo at E0. No busy, no RUN.
- start during RUN is ignored. The upstream stall guarantees this does not occur; the bench checks it anyway.
- NOP with start=1: no effect.
- Arithmetic:
  - MULT: signed 32x32 to 64-bit; hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32 to 64-bit.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divisor 0 (DIV/DIVU): the operation still runs the full DIV_CYCLES with busy=1, but hi/lo are left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall_req = d_is_md & (start | busy). This is combinational, so the stage after decode sees a start and decode stalls the same cycle.
- Reset mid-RUN: return immediately to IDLE, busy=0, hi=lo=0, and drop the pending result.
- Simultaneous start and flush in IDLE: flush wins; no launch, no MTHI/MTLO write. This applies with MD_FLUSH_EN only.

Optional Feature:
- MD_FLUSH_EN defined:
  - flush=1 in RUN aborts at the next edge: IDLE, busy=0, hi/lo keep their pre-operation values, pending is discarded.
  - flush=1 in IDLE suppresses a same-cycle start.
- MD_FLUSH_EN undefined:
  - flush is ignored and operations always complete.
  - The port remains, unused.

Decomposition:
- md_pkg holds:
  - md_op encodings (NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6).
  - State encodings IDLE/RUN.
  - Default cycle constants.
- Sub-module md_arith: combinational.
  - Inputs: op, a, b. Outputs: 64-bit result and a div_by_zero flag.
  - md_ctrl owns the FSM, counter, pending registers and HI/LO.

Test Plan:
- Signed multiply timing:
  - Stimulus: MULT, op_a=3, op_b=0xFFFFFFFE, start at E0.
  - Response: busy=1 for 5 cycles; after E5, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0.
- Unsigned multiply:
  - Stimulus: MULTU, op_a=0xFFFFFFFF, op_b=2.
  - Response: after 5 cycles, hi=1, lo=0xFFFFFFFE.
- Signed divide, then divide by zero:
  - Stimulus: DIV -7/2.
  - Response: after 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Stimulus: DIVU 7/0.
  - Response: busy for 10 cycles, hi/lo unchanged.
- Stall interaction:
  - Stimulus: d_is_md=1 held while DIV is started.
  - Response: stall_req=1 on the start cycle and on all 10 busy cycles, 0 after busy falls.
  - Stimulus: d_is_md=0.
  - Response: stall_req stays 0.
- Move-to and ignored start:
  - Stimulus: MTHI op_a=0x12345678.
  - Response: hi=0x12345678 next cycle, busy stays 0.
  - Stimulus: start MULTU during a RUN.
  - Response: ignored; the first result only is committed.
- Reset and flush:
  - Stimulus: reset asserted at cycle 3 of a DIV.
  - Response: busy=0 and hi=lo=0 immediately (asynchronous).
  - Stimulus (MD_FLUSH_EN): flush at cycle 2 of a MULT.
  - Response: busy=0 next edge, prior hi/lo retained.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared types and constants for the multiply/divide
//                sequencing controller (op codes, FSM states, latencies).
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Operation codes driven by the decode stage
    typedef enum logic [2:0] {
        NOP   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } md_op_e;

    // Controller states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Default busy durations in cycles
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // Multiply/divide ops occupy the resource; moves and NOP do not
    function automatic logic md_is_long(input logic [2:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
//  Module      : md_arith
//  Description : Combinational multiply/divide datapath. Produces the 64-bit
//                {hi,lo} result for MULT/MULTU/DIV/DIVU and a divide-by-zero
//                flag. Division works on magnitudes so the most-negative
//                dividend over -1 needs no special case.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        b_zero;
    logic [31:0] divisor;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] quot;
    logic [31:0] rem;

    // Datapath: both products, sign-magnitude divide, then select by op
    always_comb begin
        prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u  = {32'd0, a} * {32'd0, b};

        neg_a   = (op == DIV) && a[31];
        neg_b   = (op == DIV) && b[31];
        mag_a   = neg_a ? (~a + 32'd1) : a;
        mag_b   = neg_b ? (~b + 32'd1) : b;
        b_zero  = (b == 32'd0);
        // Substitute 1 so the divider never sees a zero divisor
        divisor = b_zero ? 32'd1 : mag_b;
        quot_u  = mag_a / divisor;
        rem_u   = mag_a % divisor;
        // Quotient truncates toward zero; remainder follows the dividend sign
        quot    = (neg_a ^ neg_b) ? (~quot_u + 32'd1) : quot_u;
        rem     = neg_a ? (~rem_u + 32'd1) : rem_u;

        result      = 64'd0;
        div_by_zero = 1'b0;
        case (op)
            MULT:     result = prod_s;
            MULTU:    result = prod_u;
            DIV, DIVU: begin
                result      = {rem, quot};
                div_by_zero = b_zero;
            end
            default:  result = 64'd0;
        endcase
    end

endmodule : md_arith
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_ctrl
//  Description : Sequencing controller for the shared multiply/divide unit
//                and its HI/LO registers. Launches one op per start pulse in
//                IDLE, holds busy for a fixed latency, then commits HI/LO.
//                Requests a decode stall while an md instruction would
//                collide with a launching or running operation.
//                Optional feature macro: MD_FLUSH_EN (flush aborts a running
//                operation and suppresses a same-cycle start).
//  Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        d_is_md,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_req
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_wr_q, pend_wr_d;

    logic [63:0]      arith_result;
    logic             arith_dbz;
    logic             flush_act;

`ifdef MD_FLUSH_EN
    assign flush_act = flush;
`else
    logic unused_flush;
    assign flush_act    = 1'b0;
    assign unused_flush = flush;
`endif

    md_arith u_arith (
        .op          (md_op),
        .a           (op_a),
        .b           (op_b),
        .result      (arith_result),
        .div_by_zero (arith_dbz)
    );

    // Next-state logic: launch, count down, commit or abort
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            IDLE: begin
                if (start && !flush_act) begin
                    if (md_is_long(md_op)) begin
                        state_d   = RUN;
                        busy_d    = 1'b1;
                        pend_d    = arith_result;
                        // A zero divisor still runs full length but commits nothing
                        pend_wr_d = !arith_dbz;
                        cnt_d     = ((md_op == MULT) || (md_op == MULTU)) ? MULT_LOAD : DIV_LOAD;
                    end else if (md_op == MTHI) begin
                        hi_d = op_a;
                    end else if (md_op == MTLO) begin
                        lo_d = op_a;
                    end
                end
            end
            RUN: begin
                if (flush_act) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    pend_d    = 64'd0;
                    pend_wr_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    // Combinational so decode stalls in the same cycle a start is issued
    assign stall_req = d_is_md & (start | busy_q);

endmodule : md_ctrl
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_ctrl
//  Description : Directed self-checking bench for md_ctrl with a scoreboard
//                queue of expected {hi,lo} results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        d_is_md;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_req;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .d_is_md   (d_is_md),
        .flush     (flush),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one long op, count busy cycles, then pop and compare the result
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [63:0] exp,
                          input logic dmd, input int inj);
        int cyc;
        logic [63:0] e;
        sb_q.push_back(exp);
        start = 1'b1; md_op = op; op_a = a; op_b = b; d_is_md = dmd;
        #1;
        chk({tag, "_stall_start"}, 64'(stall_req), 64'(dmd));
        step();
        start = 1'b0; md_op = NOP;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            chk({tag, "_stall_busy"}, 64'(stall_req), 64'(dmd));
            cyc++;
            if (cyc == inj) begin
                start = 1'b1; md_op = MULTU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
            end
            step();
            start = 1'b0; md_op = NOP;
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
        if (sb_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
            e = 64'd0;
        end else begin
            e = sb_q.pop_front();
        end
        chk({tag, "_result"}, {hi, lo}, e);
        chk({tag, "_stall_after"}, 64'(stall_req), 64'd0);
        d_is_md = 1'b0;
        step();
        chk({tag, "_idle_after"}, 64'(busy), 64'd0);
        chk({tag, "_result_hold"}, {hi, lo}, e);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    initial begin
        start = 1'b0; md_op = NOP; op_a = '0; op_b = '0; d_is_md = 1'b0; flush = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("reset_busy",  64'(busy), 64'd0);
        chk("reset_stall", 64'(stall_req), 64'd0);
        chk("reset_hilo",  {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();

        // Signed multiply 3 * -2, decode not md: no stall
        run_op("mult", MULT, 32'd3, 32'hFFFF_FFFE, 5, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, -1);
        // Unsigned multiply
        run_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 5, 64'h0000_0001_FFFF_FFFE, 1'b0, -1);
        // Signed divide -7/2 with decode holding an md instruction
        run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, -1);
        // Divide by zero leaves hi/lo unchanged
        run_op("divu_zero", DIVU, 32'd7, 32'd0, 10, {m_hi, m_lo}, 1'b0, -1);
        // Most-negative over -1
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 1'b0, -1);

        // Move-to HI/LO and NOP
        start = 1'b1; md_op = MTHI; op_a = 32'h1234_5678;
        step();
        start = 1'b0; md_op = NOP;
        chk("mthi_hi",   64'(hi), 64'h1234_5678);
        chk("mthi_busy", 64'(busy), 64'd0);
        start = 1'b1; md_op = MTLO; op_a = 32'h9ABC_DEF0;
        step();
        start = 1'b0;
        chk("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        start = 1'b1; md_op = NOP; op_a = 32'h5555_5555;
        step();
        start = 1'b0;
        chk("nop_busy", 64'(busy), 64'd0);
        chk("nop_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // Start during RUN is ignored
        run_op("mult_inj", MULT, 32'd2, 32'd3, 5, 64'h0000_0000_0000_0006, 1'b1, 2);

`ifdef MD_FLUSH_EN
        // Flush at cycle 2 of a MULT
        start = 1'b1; md_op = MULT; op_a = 32'd5; op_b = 32'd5;
        step();
        start = 1'b0; md_op = NOP;
        chk("flush_busy_c1", 64'(busy), 64'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
        repeat (6) step();
        chk("flush_no_commit", {hi, lo}, {m_hi, m_lo});
        // Flush suppresses a same-cycle start
        start = 1'b1; md_op = MTHI; op_a = 32'hDEAD_BEEF; flush = 1'b1;
        step();
        md_op = DIV;
        step();
        start = 1'b0; flush = 1'b0; md_op = NOP;
        chk("flush_start_busy", 64'(busy), 64'd0);
        chk("flush_start_hilo", {hi, lo}, {m_hi, m_lo});
`else
        // Flush has no effect without the feature
        flush = 1'b1;
        run_op("mult_noflush", MULT, 32'd5, 32'd5, 5, 64'h0000_0000_0000_0019, 1'b0, -1);
        flush = 1'b0;
`endif

        // Asynchronous reset at cycle 3 of a DIV
        start = 1'b1; md_op = DIV; op_a = 32'd100; op_b = 32'd7;
        step();
        start = 1'b0; md_op = NOP;
        step();
        step();
        chk("rst_pre_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (12) step();
        chk("rst_no_commit_busy", 64'(busy), 64'd0);
        chk("rst_no_commit_hilo", {hi, lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_md_ctrl
`default_nettype wire
